// File: rtl/afe_spi_multi.sv
// Write-only serial engine for AFE attenuator/switch registers, shared across
// CHANNEL_COUNT buses; one transaction at a time, steered to the latched bus.
//
// state   | meaning
// S_IDLE  | waiting for a command, divider parked at reload
// S_SETUP | first bit presented on sdi, clk low
// S_HIGH  | clk high, device samples sdi on the rising edge
// S_LOW   | clk low; next bit presented, or LE setup gap after the last bit
// S_LATCH | LE high for one half-period, then done
module afe_spi_multi #(
  parameter int CHANNEL_COUNT      = 2,
  parameter int WORD_WIDTH         = 24,
  parameter int HALF_PERIOD_CYCLES = 5,
  parameter int CHANNEL_SEL_WIDTH  = 4
) (
  input  logic                               sysClk,
  input  logic                               sysReset,
  input  logic                               csrStrobe,
  input  logic [CHANNEL_SEL_WIDTH-1:0]       csrChannel,
  input  logic [$clog2(WORD_WIDTH+1)-1:0]    csrBitCount,
  input  logic [WORD_WIDTH-1:0]              csrData,
  input  logic                               statusClear,
  output logic                               busy,
  output logic                               doneStrobe,
  output logic                               overrun,
  output logic                               badChannel,
  output logic [CHANNEL_COUNT-1:0]           spiClk,
  output logic [CHANNEL_COUNT-1:0]           spiSdi,
  output logic [CHANNEL_COUNT-1:0]           spiLe
);

  localparam int CNT_W = $clog2(WORD_WIDTH + 1);
  localparam int DIV_W = (HALF_PERIOD_CYCLES > 1) ? $clog2(HALF_PERIOD_CYCLES) : 1;
  localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(HALF_PERIOD_CYCLES - 1);
  localparam logic [CNT_W-1:0] WORD_N     = CNT_W'(WORD_WIDTH);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_HIGH, S_LOW, S_LATCH} state_t;

  state_t                       state, state_nxt;
  logic [DIV_W-1:0]             div_cnt;
  logic                         tick;
  logic [CNT_W-1:0]             bits_left, bits_left_nxt;
  logic [WORD_WIDTH-1:0]        shreg, shreg_nxt;
  logic [CHANNEL_SEL_WIDTH-1:0] chan_q, chan_nxt;
  logic                         done_q;
  logic                         cmd_busy;
  logic                         chan_ok;
  logic                         accept;
  logic [CNT_W-1:0]             n_eff;
  logic [WORD_WIDTH-1:0]        aligned;
  logic                         clk_d, sdi_d, le_d;
  logic [CHANNEL_COUNT-1:0]     sel_mask;

  // The done cycle still counts as busy so a strobe there is an overrun.
  assign cmd_busy = (state != S_IDLE) || done_q;
  assign chan_ok  = ({{(32-CHANNEL_SEL_WIDTH){1'b0}}, csrChannel} < 32'(CHANNEL_COUNT));
  assign accept   = csrStrobe && !cmd_busy && chan_ok;
  assign n_eff    = (csrBitCount == '0 || csrBitCount > WORD_N) ? WORD_N : csrBitCount;
  assign aligned  = csrData << (WORD_N - n_eff);
  assign tick     = (state != S_IDLE) && (div_cnt == '0);

  assign busy       = (state != S_IDLE);
  assign doneStrobe = done_q;

  always_ff @(posedge sysClk) begin
    if (sysReset) begin
      state     <= S_IDLE;
      bits_left <= '0;
      shreg     <= '0;
      chan_q    <= '0;
    end else begin
      state     <= state_nxt;
      bits_left <= bits_left_nxt;
      shreg     <= shreg_nxt;
      chan_q    <= chan_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    bits_left_nxt = bits_left;
    shreg_nxt     = shreg;
    chan_nxt      = chan_q;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt     = S_SETUP;
          bits_left_nxt = n_eff;
          shreg_nxt     = aligned;
          chan_nxt      = csrChannel;
        end
      end
      S_SETUP: if (tick) state_nxt = S_HIGH;
      S_HIGH: begin
        if (tick) begin
          state_nxt     = S_LOW;
          bits_left_nxt = bits_left - 1'b1;
          // Keep the last bit on sdi through the LE setup gap.
          if (bits_left != CNT_W'(1)) shreg_nxt = shreg << 1;
        end
      end
      S_LOW:   if (tick) state_nxt = (bits_left != '0) ? S_HIGH : S_LATCH;
      S_LATCH: if (tick) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    clk_d = (state_nxt == S_HIGH);
    le_d  = (state_nxt == S_LATCH);
    sdi_d = 1'b0;
    if (state_nxt == S_SETUP || state_nxt == S_HIGH || state_nxt == S_LOW)
      sdi_d = shreg_nxt[WORD_WIDTH-1];
    sel_mask = '0;
    for (int i = 0; i < CHANNEL_COUNT; i++)
      sel_mask[i] = (chan_nxt == CHANNEL_SEL_WIDTH'(i));
  end

  always_ff @(posedge sysClk) begin
    if (sysReset) begin
      div_cnt    <= DIV_RELOAD;
      done_q     <= 1'b0;
      overrun    <= 1'b0;
      badChannel <= 1'b0;
      spiClk     <= '0;
      spiSdi     <= '0;
      spiLe      <= '0;
    end else begin
      if (state == S_IDLE || div_cnt == '0) div_cnt <= DIV_RELOAD;
      else                                  div_cnt <= div_cnt - 1'b1;
      done_q <= (state == S_LATCH) && tick;

      if (csrStrobe && cmd_busy)            overrun <= 1'b1;
      else if (statusClear)                 overrun <= 1'b0;
      if (csrStrobe && !cmd_busy && !chan_ok) badChannel <= 1'b1;
      else if (statusClear)                   badChannel <= 1'b0;

      spiClk <= {CHANNEL_COUNT{clk_d}} & sel_mask;
      spiSdi <= {CHANNEL_COUNT{sdi_d}} & sel_mask;
      spiLe  <= {CHANNEL_COUNT{le_d}}  & sel_mask;
    end
  end

endmodule

// File: tb/tb_afe_spi_multi.sv
// Bench for afe_spi_multi: default build (2 buses, H=5) plus an 8-bus H=1 build.
module tb_afe_spi_multi;

  logic sysClk = 1'b0;
  always #5 sysClk = ~sysClk;

  logic        sysReset = 1'b1;
  logic        a_strobe = 1'b0, a_clear = 1'b0;
  logic [3:0]  a_chan = '0;
  logic [4:0]  a_bc = '0;
  logic [23:0] a_data = '0;
  logic        a_busy, a_done, a_ovr, a_bad;
  logic [1:0]  a_clk, a_sdi, a_le;

  logic        b_strobe = 1'b0, b_clear = 1'b0;
  logic [3:0]  b_chan = '0;
  logic [4:0]  b_bc = '0;
  logic [23:0] b_data = '0;
  logic        b_busy, b_done, b_ovr, b_bad;
  logic [7:0]  b_clk, b_sdi, b_le;

  afe_spi_multi dut_a (
    .sysClk(sysClk), .sysReset(sysReset), .csrStrobe(a_strobe), .csrChannel(a_chan),
    .csrBitCount(a_bc), .csrData(a_data), .statusClear(a_clear), .busy(a_busy),
    .doneStrobe(a_done), .overrun(a_ovr), .badChannel(a_bad),
    .spiClk(a_clk), .spiSdi(a_sdi), .spiLe(a_le));

  afe_spi_multi #(.CHANNEL_COUNT(8), .HALF_PERIOD_CYCLES(1)) dut_b (
    .sysClk(sysClk), .sysReset(sysReset), .csrStrobe(b_strobe), .csrChannel(b_chan),
    .csrBitCount(b_bc), .csrData(b_data), .statusClear(b_clear), .busy(b_busy),
    .doneStrobe(b_done), .overrun(b_ovr), .badChannel(b_bad),
    .spiClk(b_clk), .spiSdi(b_sdi), .spiLe(b_le));

  int checks = 0, failures = 0;
  bit exp_q[$];
  int st_busy, st_rises, st_le_cyc, st_le_pulses, st_done, st_other;

  // Issues one command on dut_a and observes it until the bus has been idle a while.
  task automatic do_txn(input int ch, input int bc, input logic [23:0] data,
                        input int strobe2_at, input int clr_at, input int reset_at);
    int n, idle;
    logic prev_clk, prev_le;
    logic [1:0] oth;
    bit started, ok, b;
    n = (bc == 0 || bc > 24) ? 24 : bc;
    exp_q.delete();
    for (int i = n - 1; i >= 0; i--) exp_q.push_back(data[i]);
    st_busy = 0; st_rises = 0; st_le_cyc = 0; st_le_pulses = 0; st_done = 0; st_other = 0;
    oth = ~(2'(1) << ch);
    prev_clk = 0; prev_le = 0; idle = 0; started = 0; ok = 0;
    @(negedge sysClk);
    a_strobe = 1; a_chan = 4'(ch); a_bc = 5'(bc); a_data = data;
    for (int k = 1; k <= 700; k++) begin
      @(negedge sysClk);
      if (k == reset_at + 1) begin
        checks++;
        if (a_busy !== 0 || a_clk !== 0 || a_sdi !== 0 || a_le !== 0 || a_done !== 0) begin
          failures++;
          $display("FAIL reset_abort busy=%b clk=%b sdi=%b le=%b done=%b, required all 0",
                   a_busy, a_clk, a_sdi, a_le, a_done);
        end
        exp_q.delete();
      end
      if (a_busy) begin st_busy++; started = 1; end
      if (a_clk[ch] && !prev_clk) begin
        st_rises++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL extra_rise got rise %0d on bus %0d, required %0d rises", st_rises, ch, n);
        end else begin
          b = exp_q.pop_front();
          if (a_sdi[ch] !== b) begin
            failures++;
            $display("FAIL sdi_bit rise %0d got %b required %b", st_rises, a_sdi[ch], b);
          end
        end
      end
      if (a_le[ch]) st_le_cyc++;
      if (a_le[ch] && !prev_le) st_le_pulses++;
      if (a_done) st_done++;
      if (((a_clk | a_sdi | a_le) & oth) != 0) st_other++;
      prev_clk = a_clk[ch]; prev_le = a_le[ch];
      a_strobe = (k == strobe2_at);
      if (k == strobe2_at) a_data = ~data;
      a_clear  = (k == clr_at);
      sysReset = (k == reset_at);
      if (started && !a_busy) idle++;
      if (idle >= 8) begin ok = 1; break; end
    end
    a_strobe = 0; a_clear = 0; sysReset = 0;
    checks++;
    if (!ok) begin failures++; $display("FAIL txn_timeout got no idle bus, required completion"); end
  endtask

  task automatic test_reset();
    sysReset = 1;
    repeat (3) @(negedge sysClk);
    checks++;
    if ({a_busy, a_done, a_ovr, a_bad, a_clk, a_sdi, a_le} !== '0) begin
      failures++; $display("FAIL reset_a got %b required 0", {a_busy, a_done, a_ovr, a_bad, a_clk, a_sdi, a_le});
    end
    checks++;
    if ({b_busy, b_done, b_ovr, b_bad, b_clk, b_sdi, b_le} !== '0) begin
      failures++; $display("FAIL reset_b got %b required 0", {b_busy, b_done, b_ovr, b_bad, b_clk, b_sdi, b_le});
    end
    sysReset = 0;
    @(negedge sysClk);
  endtask

  task automatic test_basic();
    do_txn(1, 24, 24'hA5C3F0, -1, -1, -1);
    checks++; if (st_rises != 24)    begin failures++; $display("FAIL basic_rises got %0d required 24", st_rises); end
    checks++; if (st_busy != 250)    begin failures++; $display("FAIL basic_busy got %0d required 250", st_busy); end
    checks++; if (st_le_cyc != 5)    begin failures++; $display("FAIL basic_le_len got %0d required 5", st_le_cyc); end
    checks++; if (st_le_pulses != 1) begin failures++; $display("FAIL basic_le_pulses got %0d required 1", st_le_pulses); end
    checks++; if (st_done != 1)      begin failures++; $display("FAIL basic_done got %0d required 1", st_done); end
    checks++; if (st_other != 0)     begin failures++; $display("FAIL basic_other_bus got %0d active cycles required 0", st_other); end
  endtask

  task automatic test_short_word();
    do_txn(0, 3, 24'hFFFFF5, -1, -1, -1);
    checks++; if (st_rises != 3)  begin failures++; $display("FAIL short_rises got %0d required 3", st_rises); end
    checks++; if (st_busy != 40)  begin failures++; $display("FAIL short_busy got %0d required 40", st_busy); end
    checks++; if (st_le_cyc != 5) begin failures++; $display("FAIL short_le_len got %0d required 5", st_le_cyc); end
    checks++; if (st_other != 0)  begin failures++; $display("FAIL short_other_bus got %0d required 0", st_other); end
    do_txn(1, 0, 24'h3C96E1, -1, -1, -1);
    checks++; if (st_rises != 24) begin failures++; $display("FAIL zero_count_rises got %0d required 24", st_rises); end
    checks++; if (st_busy != 250) begin failures++; $display("FAIL zero_count_busy got %0d required 250", st_busy); end
  endtask

  task automatic test_overrun();
    do_txn(1, 8, 24'h0000C7, 10, -1, -1);
    checks++; if (st_rises != 8) begin failures++; $display("FAIL ovr_rises got %0d required 8", st_rises); end
    checks++; if (st_busy != 90) begin failures++; $display("FAIL ovr_busy got %0d required 90", st_busy); end
    checks++; if (st_done != 1)  begin failures++; $display("FAIL ovr_done got %0d required 1", st_done); end
    checks++; if (a_ovr !== 1)   begin failures++; $display("FAIL ovr_flag got %b required 1", a_ovr); end
    checks++; if (a_bad !== 0)   begin failures++; $display("FAIL ovr_badch got %b required 0", a_bad); end
    a_clear = 1; @(negedge sysClk); a_clear = 0;
    checks++; if (a_ovr !== 0)   begin failures++; $display("FAIL ovr_clear got %b required 0", a_ovr); end
    do_txn(0, 4, 24'h000009, 10, 10, -1);
    checks++; if (a_ovr !== 1)   begin failures++; $display("FAIL ovr_set_wins got %b required 1", a_ovr); end
    checks++; if (st_busy != 50) begin failures++; $display("FAIL ovr2_busy got %0d required 50", st_busy); end
  endtask

  task automatic test_bad_channel();
    int active;
    active = 0;
    a_clear = 1; @(negedge sysClk); a_clear = 0;
    a_strobe = 1; a_chan = 4'd2; a_bc = 5'd8; a_data = 24'h0000FF;
    @(negedge sysClk);
    a_strobe = 0;
    checks++; if (a_bad !== 1) begin failures++; $display("FAIL badch_flag got %b required 1", a_bad); end
    for (int k = 0; k < 20; k++) begin
      if (a_busy || a_clk != 0 || a_sdi != 0 || a_le != 0 || a_done) active++;
      @(negedge sysClk);
    end
    checks++; if (active != 0) begin failures++; $display("FAIL badch_quiet got %0d active cycles required 0", active); end
    checks++; if (a_ovr !== 0) begin failures++; $display("FAIL badch_ovr got %b required 0", a_ovr); end
    a_clear = 1; @(negedge sysClk); a_clear = 0;
    checks++; if (a_bad !== 0) begin failures++; $display("FAIL badch_clear got %b required 0", a_bad); end
  endtask

  task automatic test_back_to_back();
    int k, busy2, rises2;
    bit seen;
    logic prev;
    @(negedge sysClk);
    a_strobe = 1; a_chan = 4'd0; a_bc = 5'd1; a_data = 24'h000001;
    @(negedge sysClk);
    a_strobe = 0;
    seen = 0;
    for (k = 0; k < 100 && !seen; k++) begin
      if (a_done) seen = 1; else @(negedge sysClk);
    end
    checks++; if (!seen) begin failures++; $display("FAIL b2b_done_timeout got no doneStrobe required one"); end
    a_strobe = 1; a_chan = 4'd1; a_bc = 5'd2; a_data = 24'h000002;
    @(negedge sysClk);
    checks++; if (a_ovr !== 1)  begin failures++; $display("FAIL b2b_done_cycle_ovr got %b required 1", a_ovr); end
    checks++; if (a_busy !== 0) begin failures++; $display("FAIL b2b_done_cycle_busy got %b required 0", a_busy); end
    @(negedge sysClk);
    a_strobe = 0;
    checks++; if (a_busy !== 1) begin failures++; $display("FAIL b2b_accept got busy=%b required 1", a_busy); end
    busy2 = 0; rises2 = 0; prev = 0; seen = 0;
    for (k = 0; k < 200 && !seen; k++) begin
      if (a_busy) busy2++;
      if (a_clk[1] && !prev) rises2++;
      prev = a_clk[1];
      if (a_done) seen = 1; else @(negedge sysClk);
    end
    checks++; if (busy2 != 30) begin failures++; $display("FAIL b2b_busy got %0d required 30", busy2); end
    checks++; if (rises2 != 2) begin failures++; $display("FAIL b2b_rises got %0d required 2", rises2); end
    a_clear = 1; @(negedge sysClk); a_clear = 0;
  endtask

  task automatic test_reset_abort();
    do_txn(1, 24, 24'hA5C3F0, -1, -1, 60);
    checks++; if (st_done != 0)      begin failures++; $display("FAIL abort_done got %0d required 0", st_done); end
    checks++; if (st_le_pulses != 0) begin failures++; $display("FAIL abort_le got %0d required 0", st_le_pulses); end
    do_txn(0, 24, 24'h123456, -1, -1, -1);
    checks++; if (st_rises != 24) begin failures++; $display("FAIL after_abort_rises got %0d required 24", st_rises); end
    checks++; if (st_busy != 250) begin failures++; $display("FAIL after_abort_busy got %0d required 250", st_busy); end
    checks++; if (st_done != 1)   begin failures++; $display("FAIL after_abort_done got %0d required 1", st_done); end
  endtask

  task automatic test_param();
    int j, other;
    bit seen, b;
    logic exp_clk;
    logic [23:0] d;
    d = 24'h0000B4;
    exp_q.delete();
    for (int i = 7; i >= 0; i--) exp_q.push_back(d[i]);
    @(negedge sysClk);
    b_strobe = 1; b_chan = 4'd7; b_bc = 5'd8; b_data = d;
    @(negedge sysClk);
    b_strobe = 0;
    j = 0; other = 0; seen = 0;
    for (int k = 0; k < 60 && !seen; k++) begin
      if (b_busy) begin
        exp_clk = (j >= 1 && j <= 16) ? ((j % 2) == 1) : 1'b0;
        checks++;
        if (b_clk[7] !== exp_clk) begin
          failures++; $display("FAIL param_clk cycle %0d got %b required %b", j, b_clk[7], exp_clk);
        end
        if (exp_clk && exp_q.size() != 0) begin
          b = exp_q.pop_front();
          checks++;
          if (b_sdi[7] !== b) begin failures++; $display("FAIL param_sdi cycle %0d got %b required %b", j, b_sdi[7], b); end
        end
        j++;
      end
      if ((b_clk | b_sdi | b_le) & 8'h7F) other++;
      if (b_done) seen = 1; else @(negedge sysClk);
    end
    checks++; if (!seen)       begin failures++; $display("FAIL param_done_timeout got no doneStrobe required one"); end
    checks++; if (j != 18)     begin failures++; $display("FAIL param_busy got %0d required 18", j); end
    checks++; if (other != 0)  begin failures++; $display("FAIL param_other_bus got %0d required 0", other); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL param_bits_left got %0d required 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_short_word();
    test_overrun();
    test_bad_channel();
    test_back_to_back();
    test_reset_abort();
    test_param();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/afe_spi_multi.md
Name: afe_spi_multi

Overview:
- Parametrised write-only serial controller for analog front-end attenuator/switch registers on the RF input boards.
- Replaces the fixed two-bus AFE SPI drive with one shared shift engine that steers to any of CHANNEL_COUNT buses.
- Supports variable word length per transaction, a programmable serial clock rate, completion pulses and sticky error status.
- Sits between the system CSR interface and the AFE_SPI_CLK/SDI/LE pins.

Parameters:
- CHANNEL_COUNT, 2, number of independent AFE SPI buses (1..16).
- WORD_WIDTH, 24, maximum bits per transaction.
- HALF_PERIOD_CYCLES, 5, sysClk cycles per serial-clock half-period (H, ≥1).
- CHANNEL_SEL_WIDTH, 4, width of the channel index input.

Ports:
- sysClk  in  1  system clock; all logic on its rising edge.
- sysReset  in  1  synchronous, active-high reset.
- csrStrobe  in  1  one-cycle command strobe.
- csrChannel  in  CHANNEL_SEL_WIDTH  target bus index.
- csrBitCount  in  clog2(WORD_WIDTH+1)  bits to send; 0 means WORD_WIDTH.
- csrData  in  WORD_WIDTH  right-justified payload.
- statusClear  in  1  clears sticky error bits.
- busy  out  1  transaction in progress.
- doneStrobe  out  1  one-cycle pulse when a transaction ends.
- overrun  out  1  sticky flag: strobe was received while busy.
- badChannel  out  1  sticky flag: csrChannel ≥ CHANNEL_COUNT.
- spiClk  out  CHANNEL_COUNT  per-bus serial clock (AFE_SPI_CLK).
- spiSdi  out  CHANNEL_COUNT  per-bus serial data (AFE_SPI_SDI).
- spiLe  out  CHANNEL_COUNT  per-bus latch enable (AFE_SPI_LE).

Behaviour:
- Reset values: all outputs 0. State goes to IDLE.
- Reset mid-transaction aborts immediately. Outputs are 0 on the following cycle. No LE pulse and no doneStrobe are issued.
- Divider: a counter reloads at H−1 and emits a tick every H cycles while not IDLE. A state advances only on a tick.
- Command acceptance in IDLE, on csrStrobe with a valid channel:
  - Latch the channel, N = (csrBitCount==0 || csrBitCount>WORD_WIDTH) ? WORD_WIDTH : csrBitCount, and the data.
  - busy = 1 from the next cycle. Enter SETUP.
- csrStrobe with an invalid channel: command dropped; badChannel set next cycle; busy stays 0.
- csrStrobe while busy: command dropped; overrun set next cycle; the active transaction is unaffected.
- Bit order: MSB first. The first bit is data[N−1] and the last is data[0].
- SETUP, one half-period: spiClk=0, spiSdi = first bit.
- HIGH, one half-period: spiClk=1, data held stable. The device samples on the rising edge.
- LOW, one half-period: spiClk=0.
  - If bits remain, spiSdi advances to the next bit at entry to LOW; next state HIGH.
  - After the last bit, LOW serves as the LE setup gap; next state LATCH.
- LATCH, one half-period: spiLe=1, spiClk=0, spiSdi=0.
- Exit: IDLE on the next tick. busy=0 and doneStrobe=1 on the same cycle.
- busy high for exactly (2N+2)·H cycles.
- Only the selected bus toggles. All other buses hold clk/sdi/le at 0.
- Serial outputs are registered: no combinational path from inputs to spi* pins.
- statusClear clears overrun and badChannel. If a new error occurs on the same cycle, set wins.
- A strobe on the cycle doneStrobe is asserted counts as busy and raises overrun. A strobe on the next cycle is accepted.

Test Plan:
- Basic transaction: H=5, channel 1, N=24, data 0xA5C3F0 -> 24 rising edges on spiClk[1] with spiSdi[1] = 1010_0101_1100_0011_1111_0000; one LE pulse 5 cycles long; busy high 250 cycles; doneStrobe once; bus 0 stays all-zero.
- Short word: N=3, data 0xFFFFF5 -> bits 1,0,1 sent and upper bits ignored; busy 40 cycles; csrBitCount=0 sends 24 bits.
- Overrun: second strobe 10 cycles into a transaction -> first transaction completes unchanged; overrun=1; no second transaction. statusClear -> overrun=0. Clear and new overrun on the same cycle -> overrun stays 1.
- Bad channel: csrChannel=2 with CHANNEL_COUNT=2 -> badChannel=1, busy never asserts, all pins 0.
- Mid-transaction reset: sysReset on cycle 60 -> all spi* and busy are 0 on cycle 61; no LE pulse and no doneStrobe. A new strobe after reset completes normally.
- Parametric build: CHANNEL_COUNT=8, H=1 -> channel 7 with N=8 produces busy for 18 cycles, and spiClk[7] toggles every cycle.
